// File: rtl/hdc_multimodal_fuser.sv
// Fold-serial majority bundler: fuses NUM_MODALITIES hypervector folds into one.
// Optional macro HDC_FUSER_TIEBREAK_EN resolves even-M ties to tb0 ^ tb1 instead of 0.
module hdc_multimodal_fuser #(
    parameter int NUM_MODALITIES  = 3,
    parameter int NUM_FOLDS       = 8,
    parameter int NUM_FOLDS_WIDTH = $clog2(NUM_FOLDS),
    parameter int FOLD_WIDTH      = 2000 / NUM_FOLDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       hvin_valid,
    output logic                       hvin_ready,
    input  logic [FOLD_WIDTH-1:0]      hvin,
    output logic                       hvout_valid,
    input  logic                       hvout_ready,
    output logic [FOLD_WIDTH-1:0]      hvout,
    output logic [NUM_FOLDS_WIDTH-1:0] hvout_fold,
    output logic                       hvout_last
);

    localparam int CNT_WIDTH = $clog2(NUM_MODALITIES + 1);
    localparam logic [CNT_WIDTH-1:0]       LAST_MOD  = CNT_WIDTH'(NUM_MODALITIES - 1);
    localparam logic [CNT_WIDTH-1:0]       HALF      = CNT_WIDTH'(NUM_MODALITIES / 2);
    localparam logic                       M_EVEN    = 1'((NUM_MODALITIES % 2) == 0);
    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_OUTPUT = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic                       hvin_ready_q, hvin_ready_d;
    logic [CNT_WIDTH-1:0]       mod_cnt_q, mod_cnt_d;
    logic [NUM_FOLDS_WIDTH-1:0] fold_cnt_q, fold_cnt_d;
    logic [CNT_WIDTH-1:0]       cnt_q [FOLD_WIDTH];
    logic [CNT_WIDTH-1:0]       cnt_d [FOLD_WIDTH];
    logic [CNT_WIDTH-1:0]       sum_s [FOLD_WIDTH];
    logic [FOLD_WIDTH-1:0]      tie_s;
    logic [FOLD_WIDTH-1:0]      hvout_q, hvout_d;
    logic [NUM_FOLDS_WIDTH-1:0] hvout_fold_q, hvout_fold_d;
    logic                       hvout_last_q, hvout_last_d;
    logic                       hvout_valid_q, hvout_valid_d;
    logic                       in_hs_s;

`ifdef HDC_FUSER_TIEBREAK_EN
    logic [FOLD_WIDTH-1:0]      tb0_q, tb0_d;
    logic [FOLD_WIDTH-1:0]      tb1_q, tb1_d;
    // For M=2 the second modality is still on hvin when the tie is resolved.
    assign tie_s = tb0_q ^ ((mod_cnt_q == CNT_WIDTH'(1)) ? hvin : tb1_q);
`else
    assign tie_s = {FOLD_WIDTH{1'b0}};
`endif

    function automatic logic fuse_bit(input logic [CNT_WIDTH-1:0] sum, input logic tie_val);
        if (sum > HALF) begin
            fuse_bit = 1'b1;
        end else if (M_EVEN && (sum == HALF)) begin
            fuse_bit = tie_val;
        end else begin
            fuse_bit = 1'b0;
        end
    endfunction

    assign in_hs_s     = hvin_valid & hvin_ready_q;
    assign hvin_ready  = hvin_ready_q;
    assign hvout_valid = hvout_valid_q;
    assign hvout       = hvout_q;
    assign hvout_fold  = hvout_fold_q;
    assign hvout_last  = hvout_last_q;

    // Per-bit vote total including the fold currently on hvin.
    always_comb begin
        for (int b = 0; b < FOLD_WIDTH; b++) begin
            sum_s[b] = cnt_q[b] + CNT_WIDTH'(hvin[b]);
        end
    end

    // Next-state logic for the accumulate/output FSM and all datapath registers.
    always_comb begin
        state_d       = state_q;
        mod_cnt_d     = mod_cnt_q;
        fold_cnt_d    = fold_cnt_q;
        cnt_d         = cnt_q;
        hvout_d       = hvout_q;
        hvout_fold_d  = hvout_fold_q;
        hvout_last_d  = hvout_last_q;
        hvout_valid_d = hvout_valid_q;
`ifdef HDC_FUSER_TIEBREAK_EN
        tb0_d         = tb0_q;
        tb1_d         = tb1_q;
`endif
        if (clear) begin
            state_d       = ST_ACCUM;
            mod_cnt_d     = '0;
            fold_cnt_d    = '0;
            hvout_valid_d = 1'b0;
            for (int b = 0; b < FOLD_WIDTH; b++) begin
                cnt_d[b] = '0;
            end
`ifdef HDC_FUSER_TIEBREAK_EN
            tb0_d = '0;
            tb1_d = '0;
`endif
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_hs_s) begin
`ifdef HDC_FUSER_TIEBREAK_EN
                        if (mod_cnt_q == CNT_WIDTH'(0)) begin
                            tb0_d = hvin;
                        end else if (mod_cnt_q == CNT_WIDTH'(1)) begin
                            tb1_d = hvin;
                        end else begin
                            tb0_d = tb0_q;
                        end
`endif
                        if (mod_cnt_q == LAST_MOD) begin
                            for (int b = 0; b < FOLD_WIDTH; b++) begin
                                hvout_d[b] = fuse_bit(sum_s[b], tie_s[b]);
                                cnt_d[b]   = '0;
                            end
                            mod_cnt_d     = '0;
                            hvout_fold_d  = fold_cnt_q;
                            hvout_last_d  = (fold_cnt_q == LAST_FOLD);
                            hvout_valid_d = 1'b1;
                            state_d       = ST_OUTPUT;
                        end else begin
                            cnt_d     = sum_s;
                            mod_cnt_d = mod_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_OUTPUT: begin
                    if (hvout_ready) begin
                        hvout_valid_d = 1'b0;
                        fold_cnt_d    = (fold_cnt_q == LAST_FOLD) ? '0
                                      : fold_cnt_q + NUM_FOLDS_WIDTH'(1);
                        state_d       = ST_ACCUM;
                    end else begin
                        state_d = ST_OUTPUT;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
        hvin_ready_d = (state_d == ST_ACCUM);
    end

    // State registers; reset discards all partial sums and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_ACCUM;
            hvin_ready_q  <= 1'b0;
            mod_cnt_q     <= '0;
            fold_cnt_q    <= '0;
            hvout_q       <= '0;
            hvout_fold_q  <= '0;
            hvout_last_q  <= 1'b0;
            hvout_valid_q <= 1'b0;
            for (int b = 0; b < FOLD_WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
`ifdef HDC_FUSER_TIEBREAK_EN
            tb0_q <= '0;
            tb1_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hvin_ready_q  <= hvin_ready_d;
            mod_cnt_q     <= mod_cnt_d;
            fold_cnt_q    <= fold_cnt_d;
            hvout_q       <= hvout_d;
            hvout_fold_q  <= hvout_fold_d;
            hvout_last_q  <= hvout_last_d;
            hvout_valid_q <= hvout_valid_d;
            cnt_q         <= cnt_d;
`ifdef HDC_FUSER_TIEBREAK_EN
            tb0_q <= tb0_d;
            tb1_q <= tb1_d;
`endif
        end
    end

endmodule

// File: tb/tb_hdc_multimodal_fuser.sv
// Bench for hdc_multimodal_fuser: an M=3 and an M=4 instance checked against a bit-vote model.
module tb_hdc_multimodal_fuser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clr3, v3, r3, ov3, or3, last3;
    logic [7:0] d3, o3;
    logic [2:0] f3;
    logic       clr4, v4, r4, ov4, or4, last4;
    logic [7:0] d4, o4;
    logic [2:0] f4;

    int tests = 0;
    int fails = 0;
    int ef3 = 0;
    int ef4 = 0;

    hdc_multimodal_fuser #(.NUM_MODALITIES(3), .NUM_FOLDS(8), .FOLD_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .clear(clr3), .hvin_valid(v3), .hvin_ready(r3), .hvin(d3),
        .hvout_valid(ov3), .hvout_ready(or3), .hvout(o3), .hvout_fold(f3), .hvout_last(last3));

    hdc_multimodal_fuser #(.NUM_MODALITIES(4), .NUM_FOLDS(8), .FOLD_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .clear(clr4), .hvin_valid(v4), .hvin_ready(r4), .hvin(d4),
        .hvout_valid(ov4), .hvout_ready(or4), .hvout(o4), .hvout_fold(f4), .hvout_last(last4));

    // Majority of m folds: a bit is set when strictly more than half vote for it.
    function automatic logic [7:0] fuse_model(input int m, input logic [7:0] a0, a1, a2, a3);
        logic [7:0] ins [4];
        logic [7:0] r;
        int c;
        ins = '{a0, a1, a2, a3};
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            c = 0;
            for (int k = 0; k < m; k++) c += int'(ins[k][b]);
            if (2 * c > m) r[b] = 1'b1;
`ifdef HDC_FUSER_TIEBREAK_EN
            else if (2 * c == m) r[b] = a0[b] ^ a1[b];
`endif
            else r[b] = 1'b0;
        end
        return r;
    endfunction

    task automatic send3(input logic [7:0] d);
        int n = 0;
        v3 = 1'b1; d3 = d;
        while (!r3 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL send3_timeout: hvin_ready stayed %b, required 1", r3); end
        @(posedge clk); #1;
        v3 = 1'b0;
    endtask

    task automatic send4(input logic [7:0] d);
        int n = 0;
        v4 = 1'b1; d4 = d;
        while (!r4 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL send4_timeout: hvin_ready stayed %b, required 1", r4); end
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    task automatic recv3(output logic [7:0] d, output logic [2:0] f, output logic l);
        int n = 0;
        while (!ov3 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL recv3_timeout: hvout_valid stayed %b, required 1", ov3); end
        d = o3; f = f3; l = last3;
        or3 = 1'b1;
        @(posedge clk); #1;
        or3 = 1'b0;
        ef3 = (ef3 + 1) % 8;
    endtask

    task automatic recv4(output logic [7:0] d, output logic [2:0] f, output logic l);
        int n = 0;
        while (!ov4 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL recv4_timeout: hvout_valid stayed %b, required 1", ov4); end
        d = o4; f = f4; l = last4;
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        ef4 = (ef4 + 1) % 8;
    endtask

    task automatic clear3();
        clr3 = 1'b1;
        @(posedge clk); #1;
        clr3 = 1'b0;
        ef3 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({r3, ov3, o3, f3, last3} !== 14'h0) begin
            fails++; $display("FAIL reset_outputs3: got %h required 0", {r3, ov3, o3, f3, last3});
        end
        tests++;
        if ({r4, ov4, o4, f4, last4} !== 14'h0) begin
            fails++; $display("FAIL reset_outputs4: got %h required 0", {r4, ov4, o4, f4, last4});
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({r3, r4} !== 2'b11) begin
            fails++; $display("FAIL reset_ready: got %b required 11", {r3, r4});
        end
    endtask

    task automatic test_majority3();
        logic [7:0] d; logic [2:0] f; logic l;
        send3(8'hF0); send3(8'hCC); send3(8'hAA);
        tests++;
        if (ov3 !== 1'b1) begin fails++; $display("FAIL maj3_latency: hvout_valid %b required 1", ov3); end
        recv3(d, f, l);
        tests++;
        if (d !== 8'hE8) begin fails++; $display("FAIL maj3_data: got %h required e8", d); end
        tests++;
        if (f !== 3'd0) begin fails++; $display("FAIL maj3_fold: got %0d required 0", f); end
    endtask

    task automatic test_tie4();
        logic [7:0] d; logic [2:0] f; logic l;
        logic [7:0] exp_v;
`ifdef HDC_FUSER_TIEBREAK_EN
        exp_v = 8'h3C;
`else
        exp_v = 8'h00;
`endif
        send4(8'hF0); send4(8'hCC); send4(8'h0F); send4(8'h33);
        recv4(d, f, l);
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL tie4_data: got %h required %h", d, exp_v); end
        tests++;
        if (f !== 3'd0) begin fails++; $display("FAIL tie4_fold: got %0d required 0", f); end
    endtask

    task automatic test_random();
        logic [7:0] a [4];
        logic [7:0] d, e; logic [2:0] f; logic l;
        int ef;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
            ef = ef3;
            send3(a[0]); send3(a[1]); send3(a[2]);
            e = fuse_model(3, a[0], a[1], a[2], 8'h00);
            recv3(d, f, l);
            tests++;
            if (d !== e || f !== 3'(ef) || l !== (ef == 7)) begin
                fails++; $display("FAIL rand3_fold%0d: got %h/%0d/%b required %h/%0d/%b", i, d, f, l, e, ef, ef == 7);
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
            ef = ef4;
            send4(a[0]); send4(a[1]); send4(a[2]); send4(a[3]);
            e = fuse_model(4, a[0], a[1], a[2], a[3]);
            recv4(d, f, l);
            tests++;
            if (d !== e || f !== 3'(ef) || l !== (ef == 7)) begin
                fails++; $display("FAIL rand4_fold%0d: got %h/%0d/%b required %h/%0d/%b", i, d, f, l, e, ef, ef == 7);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a0, a1, a2, e, d; logic [2:0] f; logic l;
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        e = fuse_model(3, a0, a1, a2, 8'h00);
        send3(a0); send3(a1); send3(a2);
        v3 = 1'b1; d3 = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (o3 !== e || ov3 !== 1'b1 || r3 !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got %h/%b/%b required %h/1/0", i, o3, ov3, r3, e);
            end
        end
        v3 = 1'b0;
        recv3(d, f, l);
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        e = fuse_model(3, a0, a1, a2, 8'h00);
        send3(a0); send3(a1); send3(a2);
        recv3(d, f, l);
        tests++;
        if (d !== e) begin fails++; $display("FAIL bp_not_consumed: got %h required %h", d, e); end
    endtask

    task automatic test_wrap();
        logic [7:0] d; logic [2:0] f; logic l;
        clear3();
        for (int i = 0; i < 9; i++) begin
            send3(8'h5A); send3(8'h5A); send3(8'h00);
            recv3(d, f, l);
            tests++;
            if (f !== 3'(i % 8) || l !== (i == 7) || d !== 8'h5A) begin
                fails++; $display("FAIL wrap_fold%0d: got %0d/%b/%h required %0d/%b/5a", i, f, l, d, i % 8, i == 7);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] d; logic [2:0] f; logic l;
        send3(8'($urandom)); send3(8'($urandom));
        clear3();
        send3(8'h01); send3(8'h01); send3(8'h00);
        recv3(d, f, l);
        tests++;
        if (d !== 8'h01 || f !== 3'd0) begin
            fails++; $display("FAIL clear_residue: got %h/%0d required 01/0", d, f);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] a0, a1, a2, e, d; logic [2:0] f; logic l;
        send3(8'hFF); send3(8'hFF); send3(8'hFF);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (ov3 !== 1'b0 || o3 !== 8'h00) begin
            fails++; $display("FAIL async_rst: got valid %b hvout %h required 0/00", ov3, o3);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        ef3 = 0; ef4 = 0;
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        e = fuse_model(3, a0, a1, a2, 8'h00);
        send3(a0); send3(a1); send3(a2);
        recv3(d, f, l);
        tests++;
        if (f !== 3'd0 || d !== e) begin
            fails++; $display("FAIL async_rst_restart: got %0d/%h required 0/%h", f, d, e);
        end
    endtask

    initial begin
        clr3 = 1'b0; v3 = 1'b0; d3 = 8'h00; or3 = 1'b0;
        clr4 = 1'b0; v4 = 1'b0; d4 = 8'h00; or4 = 1'b0;
        test_reset();
        test_majority3();
        test_tie4();
        test_random();
        test_backpressure();
        test_wrap();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
